// File: rtl/dbg_guv_pkg.sv
// Shared types and field layout for the debug governor command sequencer.
package dbg_guv_pkg;

    localparam int unsigned NUM_CHAN   = 5;
    localparam int unsigned CMD_WIDTH  = 29;
    localparam int unsigned CNT_WIDTH  = 23;
    localparam int unsigned OP_WIDTH   = 3;
    localparam int unsigned CHAN_WIDTH = 3;

    localparam int unsigned OP_MSB   = 28;
    localparam int unsigned OP_LSB   = 26;
    localparam int unsigned CHAN_MSB = 25;
    localparam int unsigned CHAN_LSB = 23;
    localparam int unsigned CNT_MSB  = 22;
    localparam int unsigned CNT_LSB  = 0;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_NOP    = 3'd0,
        OP_DROP   = 3'd1,
        OP_INJECT = 3'd2,
        OP_LOG    = 3'd3,
        OP_PAUSE  = 3'd4,
        OP_CLEAR  = 3'd5
    } op_e;

    typedef enum logic [CHAN_WIDTH-1:0] {
        CH_RDATA  = 3'd0,
        CH_WDATA  = 3'd1,
        CH_RADDR  = 3'd2,
        CH_AWADDR = 3'd3,
        CH_RESP   = 3'd4
    } chan_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Ops that drive a per-channel enable and occupy RUN.
    function automatic logic op_is_gov(input logic [OP_WIDTH-1:0] op);
        return (op == OP_DROP) || (op == OP_INJECT) ||
               (op == OP_LOG)  || (op == OP_PAUSE);
    endfunction

endpackage

// File: rtl/dbg_guv_cmd_ctrl.sv
// Debug governor command sequencer: accepts one command at a time, drives the
// selected channel enable while counting beats/cycles, then pulses done.
module dbg_guv_cmd_ctrl
    import dbg_guv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CMD_WIDTH-1:0]  cmd_in_TDATA,
    input  logic                  cmd_in_TVALID,
    output logic                  cmd_in_TREADY,
    input  logic [NUM_CHAN-1:0]   chan_beat,
    input  logic                  abort,
    output logic [NUM_CHAN-1:0]   drop_en,
    output logic [NUM_CHAN-1:0]   inject_en,
    output logic [NUM_CHAN-1:0]   log_en,
    output logic [NUM_CHAN-1:0]   pause_en,
    output logic                  busy,
    output logic                  done,
    output logic [OP_WIDTH-1:0]   done_op,
    output logic                  done_aborted,
    output logic                  cmd_err
);

    state_e                 r_state;
    state_e                 w_next_state;
    logic [OP_WIDTH-1:0]    r_op;
    logic [CHAN_WIDTH-1:0]  r_chan;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   r_aborted;
    logic                   r_cmd_err;

    logic [OP_WIDTH-1:0]    w_in_op;
    logic [CHAN_WIDTH-1:0]  w_in_chan;
    logic [CNT_WIDTH-1:0]   w_in_cnt;
    logic                   w_accept;
    logic                   w_in_illegal;
    logic                   w_start_run;
    logic [NUM_CHAN-1:0]    w_chan_sel;
    logic                   w_dec;
    logic                   w_last;

    assign w_in_op   = cmd_in_TDATA[OP_MSB:OP_LSB];
    assign w_in_chan = cmd_in_TDATA[CHAN_MSB:CHAN_LSB];
    assign w_in_cnt  = cmd_in_TDATA[CNT_MSB:CNT_LSB];

    assign w_accept     = cmd_in_TVALID && (r_state == ST_IDLE);
    assign w_in_illegal = (w_in_op > OP_CLEAR) ||
                          (w_in_chan >= CHAN_WIDTH'(NUM_CHAN));
    assign w_start_run  = op_is_gov(w_in_op) && !w_in_illegal &&
                          (w_in_cnt != CNT_WIDTH'(0));

    // One-hot decode of the latched channel.
    always_comb begin
        w_chan_sel = '0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            w_chan_sel[i] = (r_chan == CHAN_WIDTH'(i));
        end
    end

    // PAUSE counts cycles; the other ops count beats on their own channel only.
    assign w_dec  = (r_state == ST_RUN) &&
                    ((r_op == OP_PAUSE) || ((chan_beat & w_chan_sel) != '0));
    assign w_last = w_dec && (r_cnt == CNT_WIDTH'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and output decode from registered state.
    always_comb begin
        w_next_state  = r_state;
        cmd_in_TREADY = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        done_op       = '0;
        done_aborted  = 1'b0;
        drop_en       = '0;
        inject_en     = '0;
        log_en        = '0;
        pause_en      = '0;
        case (r_state)
            ST_IDLE: begin
                cmd_in_TREADY = 1'b1;
                if (w_accept) begin
                    w_next_state = w_start_run ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                case (r_op)
                    OP_DROP:   drop_en   = w_chan_sel;
                    OP_INJECT: inject_en = w_chan_sel;
                    OP_LOG:    log_en    = w_chan_sel;
                    OP_PAUSE:  pause_en  = w_chan_sel;
                    default:   ;
                endcase
                if (abort || w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                done_op      = r_op;
                done_aborted = r_aborted;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Latched command, countdown, abort flag and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= '0;
            r_chan    <= '0;
            r_cnt     <= '0;
            r_aborted <= 1'b0;
            r_cmd_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op      <= w_in_op;
                r_chan    <= w_in_chan;
                r_cnt     <= w_in_cnt;
                r_aborted <= 1'b0;
                if (w_in_op == OP_CLEAR) begin
                    r_cmd_err <= 1'b0;
                end else if (w_in_illegal) begin
                    r_cmd_err <= 1'b1;
                end
            end else if (r_state == ST_RUN) begin
                if (abort) begin
                    r_aborted <= 1'b1;
                end
                if (w_dec && (r_cnt != CNT_WIDTH'(0))) begin
                    r_cnt <= r_cnt - CNT_WIDTH'(1);
                end
            end
        end
    end

    assign cmd_err = r_cmd_err;

endmodule
